// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: one full-adder/subtractor slice, LSB first,
// WIDTH cycles per operation plus one DONE cycle.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cbo,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             m_q, m_d;
    logic             cb_q, cb_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             cbo_q, cbo_d;
    logic             ovf_q, ovf_d;

    logic             x, y, s, cb_next;
    logic [WIDTH-1:0] sr_next;

    always_comb begin
        x       = sa_q[0];
        y       = sb_q[0];
        s       = x ^ y ^ cb_q;
        cb_next = m_q ? ((~x & y) | (cb_q & ~(x ^ y)))
                      : ((x & y) | (cb_q & (x ^ y)));
        sr_next = {s, sr_q[WIDTH-1:1]};

        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        cb_d     = cb_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        cbo_d    = cbo_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    m_d     = mode;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    cb_d    = 1'b0;
                    cnt_d   = '0;
                    sr_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = sr_next;
                cb_d  = cb_next;
                cnt_d = cnt_q + CW'(1);
                // The last slice result goes straight to the outputs on this edge,
                // so s is the result MSB used for overflow.
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    result_d = sr_next;
                    cbo_d    = cb_next;
                    ovf_d    = m_q ? ((amsb_q != bmsb_q) & (s != amsb_q))
                                   : ((amsb_q == bmsb_q) & (s != amsb_q));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            m_q      <= 1'b0;
            cb_q     <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            cbo_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            cb_q     <= cb_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            cbo_q    <= cbo_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cbo    = cbo_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=8 (directed), 16 and 2 (random back-to-back).
module tb_serial_addsub;

    typedef struct packed {
        logic [15:0] res;
        logic        cbo;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;

    logic       start8, mode8, busy8, done8, cbo8, ovf8;
    logic [7:0] a8, b8, result8;
    logic        start16, mode16, busy16, done16, cbo16, ovf16;
    logic [15:0] a16, b16, result16;
    logic       start2, mode2, busy2, done2, cbo2, ovf2;
    logic [1:0] a2, b2, result2;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q2[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int prev16 = -1;
    int prev2 = -1;
    int av16, bv16, av2, bv2;
    logic m16r, m2r;

    serial_addsub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cbo(cbo8), .ovf(ovf8)
    );
    serial_addsub #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .cbo(cbo16), .ovf(ovf16)
    );
    serial_addsub #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(result2), .cbo(cbo2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Plain integer arithmetic reference; operands are already masked to w bits.
    function automatic exp_t model(int w, int av, int bv, logic m);
        exp_t e;
        int r, mask, ra, rb, rr;
        mask  = (1 << w) - 1;
        r     = m ? (av - bv) : (av + bv);
        e.res = 16'(r & mask);
        e.cbo = m ? (av < bv) : (((r >> w) & 1) != 0);
        ra    = (av >> (w - 1)) & 1;
        rb    = (bv >> (w - 1)) & 1;
        rr    = ((r & mask) >> (w - 1)) & 1;
        e.ovf = m ? ((ra != rb) && (rr != ra)) : ((ra == rb) && (rr != ra));
        return e;
    endfunction

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic m,
                                 input bit push);
        @(negedge clk);
        a8     = av;
        b8     = bv;
        mode8  = m;
        start8 = 1'b1;
        if (push) q8.push_back(model(8, int'(av), int'(bv), m));
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300; i++) begin
            if (q8.size() == 0 && q16.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain", q8.size() + q16.size() + q2.size(), 0);
    endtask

    always @(negedge clk) begin
        if (done8) begin
            exp_t e;
            checkOutput("q8_pending", q8.size() != 0, 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                checkOutput("res8", {24'b0, result8}, {16'b0, e.res});
                checkOutput("cbo8", cbo8, e.cbo);
                checkOutput("ovf8", ovf8, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            exp_t e;
            checkOutput("q16_pending", q16.size() != 0, 1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                checkOutput("res16", {16'b0, result16}, {16'b0, e.res});
                checkOutput("cbo16", cbo16, e.cbo);
                checkOutput("ovf16", ovf16, e.ovf);
            end
            if (prev16 >= 0) checkOutput("interval16", cyc - prev16, 18);
            prev16 = cyc;
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            exp_t e;
            checkOutput("q2_pending", q2.size() != 0, 1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                checkOutput("res2", {30'b0, result2}, {16'b0, e.res});
                checkOutput("cbo2", cbo2, e.cbo);
                checkOutput("ovf2", ovf2, e.ovf);
            end
            if (prev2 >= 0) checkOutput("interval2", cyc - prev2, 4);
            prev2 = cyc;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start8  = 1'b0; mode8  = 1'b0; a8  = '0; b8  = '0;
        start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
        start2  = 1'b0; mode2  = 1'b0; a2  = '0; b2  = '0;
        #23;
        checkOutput("rst_busy", busy8, 0);
        checkOutput("rst_done", done8, 0);
        checkOutput("rst_result", {24'b0, result8}, 0);
        checkOutput("rst_cbo", cbo8, 0);
        checkOutput("rst_ovf", ovf8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and pulse width of done / busy around the first operation.
        applyStimulus(8'h3C, 8'h0F, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("lat_done_c%0d", k), done8, (k == 9) ? 1 : 0);
            checkOutput($sformatf("lat_busy_c%0d", k), busy8, (k <= 9) ? 1 : 0);
        end

        // A start pulse mid-run must be ignored; outputs hold until done.
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_res_c%0d", k), {24'b0, result8}, 32'h4B);
            checkOutput($sformatf("hold_cbo_c%0d", k), cbo8, 0);
            checkOutput($sformatf("hold_ovf_c%0d", k), ovf8, 0);
            if (k == 3) begin
                a8 = 8'h7F; b8 = 8'h01; mode8 = 1'b1; start8 = 1'b1;
            end
            if (k == 4) start8 = 1'b0;
        end
        repeat (14) @(negedge clk);
        waitDrain();

        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1);
        waitDrain();

        // Abort mid-run: outputs drop to reset values at once, no done.
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy8, 0);
        checkOutput("abort_done", done8, 0);
        checkOutput("abort_result", {24'b0, result8}, 0);
        checkOutput("abort_cbo", cbo8, 0);
        checkOutput("abort_ovf", ovf8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        applyStimulus(8'h05, 8'h07, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(8'h80, 8'h01, 1'b1, 1'b1);
        waitDrain();

        prev16 = -1;
        prev2  = -1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    av16 = int'($urandom_range(0, 65535));
                    bv16 = int'($urandom_range(0, 65535));
                    m16r = 1'($urandom_range(0, 1));
                    a16 = av16[15:0]; b16 = bv16[15:0]; mode16 = m16r; start16 = 1'b1;
                    q16.push_back(model(16, av16, bv16, m16r));
                    @(posedge clk);
                    repeat (17) @(posedge clk);
                end
                @(negedge clk);
                start16 = 1'b0;
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    av2 = int'($urandom_range(0, 3));
                    bv2 = int'($urandom_range(0, 3));
                    m2r = 1'($urandom_range(0, 1));
                    a2 = av2[1:0]; b2 = bv2[1:0]; mode2 = m2r; start2 = 1'b1;
                    q2.push_back(model(2, av2, bv2, m2r));
                    @(posedge clk);
                    repeat (3) @(posedge clk);
                end
                @(negedge clk);
                start2 = 1'b0;
            end
        join
        waitDrain();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
